// File: rtl/hazard_scoreboard_if.sv
// Decode/execute/writeback hazard signals and stall controls
// exchanged between the pipeline and the load-use scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_AW    = 4,
    parameter int MAX_STALL = 7
);
    localparam int NREG = 1 << REG_AW;
    localparam int SCW  =
        ($clog2(MAX_STALL + 1) > 1) ? $clog2(MAX_STALL + 1) : 1;

    logic              d_valid;
    logic [REG_AW-1:0] d_raddr1;
    logic [REG_AW-1:0] d_raddr2;
    logic              d_use1;
    logic              d_use2;
    logic              e_valid;
    logic              e_isLoad;
    logic [REG_AW-1:0] e_wreg;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_wreg;
    logic              flush;
    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_stall;
    logic              inst_stall;
    logic [NREG-1:0]   busy_vec;
    logic [SCW-1:0]    stall_count;
    logic              stall_err;

    modport master (
        output d_valid, d_raddr1, d_raddr2, d_use1, d_use2,
        output e_valid, e_isLoad, e_wreg,
        output wb_valid, wb_wreg, flush,
        input  pc_stall, ifid_stall, idex_stall, inst_stall,
        input  busy_vec, stall_count, stall_err
    );

    modport slave (
        input  d_valid, d_raddr1, d_raddr2, d_use1, d_use2,
        input  e_valid, e_isLoad, e_wreg,
        input  wb_valid, wb_wreg, flush,
        output pc_stall, ifid_stall, idex_stall, inst_stall,
        output busy_vec, stall_count, stall_err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit with a per-register busy scoreboard for
// multi-cycle loads, plus a consecutive-stall watchdog.
module hazard_scoreboard #(
    parameter int REG_AW    = 4,
    parameter int LOAD_LAT  = 2,
    parameter int MAX_STALL = 7
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave hs
);
    localparam int NREG = 1 << REG_AW;
    localparam int CW   =
        ($clog2(LOAD_LAT + 1) > 1) ? $clog2(LOAD_LAT + 1) : 1;
    localparam int SCW  =
        ($clog2(MAX_STALL + 1) > 1) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [CW-1:0]  SET_VAL = CW'(LOAD_LAT);
    localparam logic [SCW-1:0] SC_MAX  = SCW'(MAX_STALL);

    logic [CW-1:0]  cnt [NREG];
    logic [NREG-1:0] busy;
    logic            e_load;
    logic            hit1;
    logic            hit2;
    logic            stall;
    logic [SCW-1:0]  stall_count_q;
    logic            stall_err_q;

    always_comb begin
        e_load = hs.e_valid && hs.e_isLoad;
        hit1   = (hs.d_raddr1 != '0) &&
                 ((cnt[hs.d_raddr1] != '0) ||
                  (e_load && hs.e_wreg == hs.d_raddr1));
        hit2   = (hs.d_raddr2 != '0) &&
                 ((cnt[hs.d_raddr2] != '0) ||
                  (e_load && hs.e_wreg == hs.d_raddr2));
        stall  = hs.d_valid && !hs.flush &&
                 ((hs.d_use1 && hit1) || (hs.d_use2 && hit2));
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    assign hs.pc_stall    = stall;
    assign hs.ifid_stall  = stall;
    assign hs.idex_stall  = stall;
    assign hs.inst_stall  = stall;
    assign hs.busy_vec    = busy;
    assign hs.stall_count = stall_count_q;
    assign hs.stall_err   = stall_err_q;

    // Set beats clear beats decrement; flush only squashes the E set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (e_load && !hs.flush &&
                    hs.e_wreg == REG_AW'(r)) begin
                    cnt[r] <= SET_VAL;
                end else if (hs.wb_valid &&
                             hs.wb_wreg == REG_AW'(r)) begin
                    cnt[r] <= '0;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
            stall_err_q   <= 1'b0;
        end else begin
            if (!stall) begin
                stall_count_q <= '0;
            end else if (stall_count_q != SC_MAX) begin
                stall_count_q <= stall_count_q + SCW'(1);
            end
            if (stall && stall_count_q >= SC_MAX - SCW'(1)) begin
                stall_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the load-use scoreboard, LOAD_LAT=2,
// MAX_STALL=7, REG_AW=4.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    hazard_scoreboard_if #(.REG_AW(4), .MAX_STALL(7)) hs ();

    hazard_scoreboard #(
        .REG_AW(4), .LOAD_LAT(2), .MAX_STALL(7)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hs   (hs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hs.d_valid  = 0; hs.d_raddr1 = 0; hs.d_raddr2 = 0;
        hs.d_use1   = 0; hs.d_use2   = 0;
        hs.e_valid  = 0; hs.e_isLoad = 0; hs.e_wreg   = 0;
        hs.wb_valid = 0; hs.wb_wreg  = 0; hs.flush    = 0;
    endtask

    task automatic load_e(input logic [3:0] r);
        hs.e_valid = 1; hs.e_isLoad = 1; hs.e_wreg = r;
    endtask

    task automatic bubble_e();
        hs.e_valid = 0; hs.e_isLoad = 0; hs.e_wreg = 0;
    endtask

    task automatic read1(input logic [3:0] r);
        hs.d_valid = 1; hs.d_raddr1 = r; hs.d_use1 = 1;
    endtask

    function automatic logic [3:0] stalls();
        return {hs.pc_stall, hs.ifid_stall,
                hs.idex_stall, hs.inst_stall};
    endfunction

    initial begin
        idle();
        #12;
        chk("rst_busy", 32'(hs.busy_vec), 0);
        chk("rst_cnt", 32'(hs.stall_count), 0);
        chk("rst_err", 32'(hs.stall_err), 0);
        chk("rst_stall", 32'(stalls()), 0);
        rst_n = 1;
        tick();

        // basic load-use: 3 stall cycles
        load_e(3); read1(3); #1;
        chk("t1_e_stall", 32'(stalls()), 4'hf);
        chk("t1_e_busy3", 32'(hs.busy_vec[3]), 0);
        tick();
        bubble_e(); #1;
        chk("t1_c2_stall", 32'(hs.pc_stall), 1);
        chk("t1_c2_busy", 32'(hs.busy_vec), 16'h0008);
        chk("t1_c2_cnt", 32'(hs.stall_count), 1);
        tick();
        chk("t1_c1_stall", 32'(hs.idex_stall), 1);
        chk("t1_c1_busy", 32'(hs.busy_vec), 16'h0008);
        chk("t1_c1_cnt", 32'(hs.stall_count), 2);
        tick();
        chk("t1_done_stall", 32'(stalls()), 0);
        chk("t1_done_busy", 32'(hs.busy_vec), 0);
        chk("t1_done_cnt", 32'(hs.stall_count), 3);
        tick();
        chk("t1_cnt_zero", 32'(hs.stall_count), 0);

        // early release via wb_valid
        load_e(3); read1(3); #1;
        chk("t2_e_stall", 32'(hs.ifid_stall), 1);
        tick();
        bubble_e(); hs.wb_valid = 1; hs.wb_wreg = 3; #1;
        chk("t2_wb_stall", 32'(hs.inst_stall), 1);
        tick();
        hs.wb_valid = 0; #1;
        chk("t2_rel_stall", 32'(hs.pc_stall), 0);
        chk("t2_rel_busy", 32'(hs.busy_vec), 0);
        chk("t2_rel_cnt", 32'(hs.stall_count), 2);
        idle();
        tick();

        // r0 is never a hazard; unused source ignored
        load_e(0); read1(0); #1;
        chk("t3_r0_stall", 32'(hs.pc_stall), 0);
        tick();
        chk("t3_r0_busy", 32'(hs.busy_vec), 0);
        load_e(5); hs.d_raddr2 = 5; hs.d_use2 = 0; #1;
        chk("t3_nouse_e", 32'(hs.pc_stall), 0);
        tick();
        bubble_e(); #1;
        chk("t3_nouse_cnt", 32'(hs.pc_stall), 0);
        chk("t3_busy5", 32'(hs.busy_vec), 16'h0020);
        idle();
        tick();
        tick();
        chk("t3_drain", 32'(hs.busy_vec), 0);

        // flush squashes the E load and masks stall
        load_e(4); read1(4); hs.flush = 1; #1;
        chk("t4_flush_stall", 32'(hs.pc_stall), 0);
        tick();
        bubble_e(); hs.flush = 0; #1;
        chk("t4_flush_busy", 32'(hs.busy_vec), 0);
        chk("t4_flush_after", 32'(hs.pc_stall), 0);
        idle();
        load_e(4);
        tick();
        bubble_e(); hs.flush = 1; #1;
        chk("t4_old_busy", 32'(hs.busy_vec), 16'h0010);
        tick();
        hs.flush = 0; read1(4); #1;
        chk("t4_old_stall", 32'(hs.pc_stall), 1);
        chk("t4_old_busy2", 32'(hs.busy_vec), 16'h0010);
        idle();
        tick();
        tick();

        // set beats clear on the same register
        load_e(6);
        tick();
        hs.wb_valid = 1; hs.wb_wreg = 6;
        tick();
        idle(); #1;
        chk("t5_set_win", 32'(hs.busy_vec), 16'h0040);
        tick();
        chk("t5_lat_hold", 32'(hs.busy_vec), 16'h0040);
        tick();
        chk("t5_lat_end", 32'(hs.busy_vec), 0);

        // back-to-back loads, independent counters
        load_e(1);
        tick();
        load_e(2);
        tick();
        idle(); #1;
        chk("t5_b2b_both", 32'(hs.busy_vec), 16'h0006);
        tick();
        chk("t5_b2b_r2", 32'(hs.busy_vec), 16'h0004);
        tick();
        chk("t5_b2b_none", 32'(hs.busy_vec), 0);

        // watchdog: repeated sets keep D stalled
        load_e(7); read1(7);
        for (int i = 0; i < 6; i++) tick();
        chk("t6_cnt6", 32'(hs.stall_count), 6);
        chk("t6_err_lo", 32'(hs.stall_err), 0);
        tick();
        chk("t6_cnt7", 32'(hs.stall_count), 7);
        chk("t6_err_hi", 32'(hs.stall_err), 1);
        tick();
        tick();
        chk("t6_cnt_sat", 32'(hs.stall_count), 7);
        idle();
        tick();
        chk("t6_cnt_clr", 32'(hs.stall_count), 0);
        chk("t6_err_sticky", 32'(hs.stall_err), 1);

        // async reset mid-stall
        load_e(7); read1(7);
        tick();
        tick();
        bubble_e(); #1;
        chk("t7_pre_stall", 32'(hs.pc_stall), 1);
        chk("t7_pre_cnt", 32'(hs.stall_count), 2);
        #2;
        rst_n = 0;
        #1;
        chk("t7_rst_stall", 32'(stalls()), 0);
        chk("t7_rst_busy", 32'(hs.busy_vec), 0);
        chk("t7_rst_cnt", 32'(hs.stall_count), 0);
        chk("t7_rst_err", 32'(hs.stall_err), 0);
        idle();
        tick();
        rst_n = 1;
        tick();
        chk("t7_post_err", 32'(hs.stall_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
